bus_copy_master: RTL and testbench
==================================

// Module: bus_copy_master
// PURPOSE
//  Second initiator on the native data bus (addr/we/be/wdata, registered rdata one cycle after address).
//  Copies a block of 32-bit words from a source to a destination address (DMEM, GPIO, TIMER, UART).
//  Requests the bus from the system arbiter, then runs read-capture-write sequences per word.
//  Reports busy/done to its controller. The address decoder and data mux handle routing.
// PARAMETERS
//  LEN_WIDTH   12   width of word-count field; max transfer (2^LEN_WIDTH)-1 words
// PORTS
//  clk          in   1          system clock
//  rst_n        in   1          asynchronous, active-low reset
//  start        in   1          1-cycle pulse: latch src/dst/word_cnt, begin copy
//  abort        in   1          stop after the word currently in flight is written
//  src_addr     in   32         source byte address; bits [1:0] ignored (forced 00)
//  dst_addr     in   32         destination byte address; bits [1:0] ignored (forced 00)
//  word_cnt     in   LEN_WIDTH  number of words to copy
//  busy         out  1          transfer in progress
//  done         out  1          1-cycle pulse at end of transfer (normal, zero-length or abort)
//  remaining    out  LEN_WIDTH  words not yet written
//  bus_req      out  1          bus request to arbiter
//  bus_gnt      in   1          bus grant from arbiter
//  bus_addr     out  32         bus byte address
//  bus_we       out  1          write strobe
//  bus_be       out  4          byte enables (4'hF on writes, 4'h0 otherwise)
//  bus_wdata    out  32         write data
//  bus_rdata    in   32         read data, valid the cycle after the read address
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; busy=0, done=0, bus_req=0, bus_we=0, bus_be=0,
//   bus_addr=0, bus_wdata=0, remaining=0, internal src/dst/data registers=0. Any transfer is dropped
//   immediately with no done pulse. After rst_n rises, first action is the next start.
//  FSM states and transitions:
//   IDLE: outputs idle. start & word_cnt!=0 -> REQ (latch addrs, remaining=word_cnt).
//         start & word_cnt==0 -> DONE (no bus access).
//   REQ:  bus_req=1, busy=1. bus_gnt -> RD; otherwise stay.
//   RD:   bus_req=1, bus_addr=src_q, bus_we=0. -> CAP.
//   CAP:  bus_req=1, bus_addr=src_q, bus_we=0. data_q<=bus_rdata. -> WR.
//   WR:   bus_req=1, bus_addr=dst_q, bus_we=1, bus_be=4'hF, bus_wdata=data_q.
//         src_q+=4, dst_q+=4, remaining-=1.
//         Last word (remaining==1) or abort_pend -> DONE. Else bus_gnt -> RD. Else -> REQ.
//   DONE: done=1 for exactly one cycle, busy=0, bus_req=0. -> IDLE.
//  Timing: 3 cycles per word while the grant is held. N words from start to done is 1+3N+1 cycles
//   (start, REQ, RD/CAP/WR xN, DONE).
//  Arbitration: the arbiter holds bus_gnt from RD through WR of a word. bus_gnt is sampled only
//   in REQ and WR. When the grant drops at WR, the next word waits in REQ with bus_req still high.
//  Abort: sets abort_pend in any non-IDLE state; cleared in DONE.
//   Abort in REQ: -> DONE next cycle with no further access.
//   Abort in RD/CAP/WR: the current word completes its write, then -> DONE.
//   remaining reports the unwritten words.
//  start while not IDLE is ignored, and the latched parameters are unchanged.
//  Simultaneous start and abort in IDLE: start wins, abort is ignored.
//  Address arithmetic: 32-bit modulo add; 0xFFFF_FFFC + 4 wraps to 0x0000_0000.
//  Overlapping src/dst: no hazard handling; words are copied in ascending order only.
// TESTING
//  1. start, src=0x1000_0100, dst=0x1000_0200, cnt=4, gnt tied 1 -> 4 read/write pairs,
//     dst words equal src words, done pulses 14 cycles after start, remaining=0.
//  2. start with cnt=0 -> no bus_req or bus_we, done pulses the cycle after start, busy stays 0.
//  3. cnt=3, gnt low for 5 cycles then high, and gnt dropped at the WR of word 1 ->
//     master waits in REQ, no accesses without a grant, all 3 words copied, done asserted once.
//  4. cnt=8, abort pulsed during CAP of word 2 -> word 2 written, no word 3 access,
//     done pulses, remaining=6.
//  5. rst_n low during WR of word 1 of 4 -> outputs go to reset values asynchronously, no done.
//     A new start after reset copies cleanly.
//  6. src=0xFFFF_FFFC, cnt=2 -> reads at 0xFFFF_FFFC then 0x0000_0000.
//     A start pulse mid-transfer is ignored.

Source files
------------

// File: rtl/bus_copy_master.sv
// bus_copy_master: second bus initiator that copies a block of 32-bit words from src to dst, one read-capture-write per word.
// Latency: start cycle + 1 REQ cycle + 3 cycles per word (grant held) + 1 DONE cycle.
// Backpressure: a low bus_gnt parks the master in REQ with bus_req high; abort lets the word in flight finish its write.
module bus_copy_master #(
    parameter int LEN_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [31:0]          src_addr,
    input  logic [31:0]          dst_addr,
    input  logic [LEN_WIDTH-1:0] word_cnt,
    output logic                 busy,
    output logic                 done,
    output logic [LEN_WIDTH-1:0] remaining,
    output logic                 bus_req,
    input  logic                 bus_gnt,
    output logic [31:0]          bus_addr,
    output logic                 bus_we,
    output logic [3:0]           bus_be,
    output logic [31:0]          bus_wdata,
    input  logic [31:0]          bus_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RD,
        S_CAP,
        S_WR,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          src_q, src_d;
    logic [31:0]          dst_q, dst_d;
    logic [31:0]          data_q, data_d;
    logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
    logic                 abort_pend_q, abort_pend_d;
    logic                 last_word;

    assign last_word = (remaining_q == LEN_WIDTH'(1));
    assign remaining = remaining_q;

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        data_d       = data_q;
        remaining_d  = remaining_q;
        abort_pend_d = abort_pend_q;
        busy         = 1'b0;
        done         = 1'b0;
        bus_req      = 1'b0;
        bus_addr     = 32'h0;
        bus_we       = 1'b0;
        bus_be       = 4'h0;
        bus_wdata    = 32'h0;

        // An abort seen while idle never sticks, so a simultaneous start wins.
        if (abort && state_q != S_IDLE) begin
            abort_pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d       = {src_addr[31:2], 2'b00};
                    dst_d       = {dst_addr[31:2], 2'b00};
                    remaining_d = word_cnt;
                    state_d     = (word_cnt == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                busy    = 1'b1;
                bus_req = 1'b1;
                if (abort || abort_pend_q) begin
                    state_d = S_DONE;
                end else if (bus_gnt) begin
                    state_d = S_RD;
                end
            end
            S_RD: begin
                busy     = 1'b1;
                bus_req  = 1'b1;
                bus_addr = src_q;
                state_d  = S_CAP;
            end
            S_CAP: begin
                busy     = 1'b1;
                bus_req  = 1'b1;
                bus_addr = src_q;
                data_d   = bus_rdata;
                state_d  = S_WR;
            end
            S_WR: begin
                busy        = 1'b1;
                bus_req     = 1'b1;
                bus_addr    = dst_q;
                bus_we      = 1'b1;
                bus_be      = 4'hF;
                bus_wdata   = data_q;
                src_d       = src_q + 32'd4;
                dst_d       = dst_q + 32'd4;
                remaining_d = remaining_q - LEN_WIDTH'(1);
                // Grant held across the write lets the next word skip REQ.
                if (last_word || abort || abort_pend_q) begin
                    state_d = S_DONE;
                end else if (bus_gnt) begin
                    state_d = S_RD;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                abort_pend_d = 1'b0;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            src_q        <= 32'h0;
            dst_q        <= 32'h0;
            data_q       <= 32'h0;
            remaining_q  <= '0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            data_q       <= data_d;
            remaining_q  <= remaining_d;
            abort_pend_q <= abort_pend_d;
        end
    end

endmodule

// File: tb/tb_bus_copy_master.sv
// Bench for bus_copy_master: a word memory on the bus, a random arbiter, and a reference model that replays
// each copy as an ascending word loop over a shadow memory.
module tb_bus_copy_master;
    localparam int LW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [31:0]   src_addr;
    logic [31:0]   dst_addr;
    logic [LW-1:0] word_cnt;
    logic          busy;
    logic          done;
    logic [LW-1:0] remaining;
    logic          bus_req;
    logic          bus_gnt;
    logic [31:0]   bus_addr;
    logic          bus_we;
    logic [3:0]    bus_be;
    logic [31:0]   bus_wdata;
    logic [31:0]   bus_rdata;

    always #5 clk = ~clk;

    bus_copy_master #(.LEN_WIDTH(LW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .word_cnt  (word_cnt),
        .busy      (busy),
        .done      (done),
        .remaining (remaining),
        .bus_req   (bus_req),
        .bus_gnt   (bus_gnt),
        .bus_addr  (bus_addr),
        .bus_we    (bus_we),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus memory; unwritten words read as a seeded hash of their address.
    logic [31:0] seed;
    logic [31:0] mem  [logic [31:0]];
    logic [31:0] refm [logic [31:0]];

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : init_val(a);
    endfunction
    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return refm.exists(a) ? refm[a] : init_val(a);
    endfunction

    always @(posedge clk) begin
        bus_rdata <= mem_rd(bus_addr);
        if (rst_n && bus_we && bus_be == 4'hF) mem[bus_addr] = bus_wdata;
    end

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         wr_log[$];
    logic [31:0] rd_log[$];
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          req_cnt  = 0;
    int          we_cnt   = 0;
    int          busy_cnt = 0;
    int          viol_cnt = 0;
    logic        prev_rd  = 1'b0;
    logic        prev_gnt = 1'b0;

    always @(negedge clk) begin : mon
        logic rd_now;
        rd_now = rst_n && bus_req && !bus_we && (bus_addr != 32'h0);
        if (rd_now && !prev_rd) begin
            rd_log.push_back(bus_addr);
            if (!prev_gnt) viol_cnt++;
        end
        if (bus_we) wr_log.push_back(wr_t'({bus_addr, bus_wdata}));
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus_req) req_cnt++;
        if (bus_we) we_cnt++;
        if (busy) busy_cnt++;
        prev_rd  = rd_now;
        prev_gnt = bus_gnt;
    end

    // Reference: ascending word-by-word copy over the shadow memory.
    wr_t exp_wr[$];
    task automatic model_copy(input logic [31:0] src, input logic [31:0] dst, input int n);
        logic [31:0] s, d;
        exp_wr.delete();
        s = {src[31:2], 2'b00};
        d = {dst[31:2], 2'b00};
        for (int i = 0; i < n; i++) begin
            refm[d] = ref_rd(s);
            exp_wr.push_back(wr_t'({d, refm[d]}));
            s = s + 32'd4;
            d = d + 32'd4;
        end
    endtask

    function automatic int wr_diff(input int base);
        if (wr_log.size() - base != exp_wr.size()) return -2;
        for (int i = 0; i < exp_wr.size(); i++) begin
            if (wr_log[base + i] !== exp_wr[i]) return i;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [LW-1:0] n,
                            input logic ab, output int sc);
        src_addr = s;
        dst_addr = d;
        word_cnt = n;
        start    = 1'b1;
        abort    = ab;
        sc       = cyc;
        tick();
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt > base) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    function automatic logic [31:0] rand_addr();
        return 32'h1000_0000 | ($urandom & 32'h00FF_FFFC);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, bus_req, bus_we, bus_be, bus_addr, bus_wdata, remaining} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h, want all zero",
                     {busy, done, bus_req, bus_we, bus_be, bus_addr, bus_wdata, remaining});
        end
        tick();
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        tests_run++;
        if ({busy, done, bus_req, bus_we, remaining} !== '0) begin
            tests_failed++;
            $display("FAIL reset_idle: busy=%b done=%b req=%b we=%b rem=%0d, want all zero",
                     busy, done, bus_req, bus_we, remaining);
        end
    endtask

    task automatic test_basic();
        int sc, d0, w0, r0, r, bad;
        bit ok, rd_ok;
        logic [31:0] ea;
        d0 = done_cnt; w0 = wr_log.size(); r0 = rd_log.size();
        bus_gnt = 1'b1;
        model_copy(32'h1000_0100, 32'h1000_0200, 4);
        do_start(32'h1000_0100, 32'h1000_0200, LW'(4), 1'b0, sc);
        wait_done(d0, 40, ok);
        repeat (3) tick();
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL basic_timeout: no done within 40 cycles"); end
        tests_run++;
        if (done_cyc - sc !== 14) begin
            tests_failed++; $display("FAIL basic_latency: got %0d cycles, want 14", done_cyc - sc);
        end
        tests_run++;
        r = wr_diff(w0);
        if (r != -1) begin
            tests_failed++;
            $display("FAIL basic_writes: code %0d, got %0d writes, want %0d", r, wr_log.size() - w0, exp_wr.size());
        end
        rd_ok = (rd_log.size() - r0 == 4);
        ea = 32'h1000_0100;
        for (int i = 0; i < 4; i++) begin
            if (rd_log.size() > r0 + i && rd_log[r0 + i] !== ea) rd_ok = 1'b0;
            ea = ea + 32'd4;
        end
        tests_run++;
        if (!rd_ok) begin
            tests_failed++; $display("FAIL basic_reads: got %0d read starts, want 4 ascending from 10000100", rd_log.size() - r0);
        end
        tests_run++;
        if (remaining !== LW'(0)) begin tests_failed++; $display("FAIL basic_remaining: got %0d, want 0", remaining); end
        tests_run++;
        if (done_cnt - d0 !== 1) begin tests_failed++; $display("FAIL basic_done_count: got %0d, want 1", done_cnt - d0); end
        bad = 0;
        for (int i = 0; i < 4; i++) if (mem_rd(32'h1000_0200 + 32'(4 * i)) !== ref_rd(32'h1000_0200 + 32'(4 * i))) bad++;
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL basic_dst_mem: %0d words differ, want 0", bad); end
    endtask

    task automatic test_zero_len();
        int sc, d0, q0, e0, b0;
        d0 = done_cnt; q0 = req_cnt; e0 = we_cnt; b0 = busy_cnt;
        do_start(rand_addr(), rand_addr(), LW'(0), 1'b0, sc);
        repeat (3) tick();
        tests_run++;
        if (done_cnt - d0 !== 1 || done_cyc !== sc + 1) begin
            tests_failed++;
            $display("FAIL zero_done: got %0d pulses at +%0d, want 1 at +1", done_cnt - d0, done_cyc - sc);
        end
        tests_run++;
        if (req_cnt != q0 || we_cnt != e0 || busy_cnt != b0) begin
            tests_failed++;
            $display("FAIL zero_no_access: req %0d we %0d busy %0d cycles, want 0 0 0",
                     req_cnt - q0, we_cnt - e0, busy_cnt - b0);
        end
        tests_run++;
        if (remaining !== LW'(0)) begin tests_failed++; $display("FAIL zero_remaining: got %0d, want 0", remaining); end
    endtask

    task automatic test_grant();
        int sc, d0, w0, v0, r;
        bit ok, wait1, wait2;
        logic we_at_wr;
        logic [31:0] s, d;
        s = rand_addr(); d = rand_addr();
        d0 = done_cnt; w0 = wr_log.size(); v0 = viol_cnt;
        bus_gnt = 1'b0;
        model_copy(s, d, 3);
        do_start(s, d, LW'(3), 1'b0, sc);
        wait1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (!(bus_req === 1'b1 && bus_we === 1'b0 && busy === 1'b1)) wait1 = 1'b0;
            tick();
        end
        bus_gnt = 1'b1;
        repeat (3) tick();
        we_at_wr = bus_we;
        bus_gnt = 1'b0;
        wait2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (!(bus_req === 1'b1 && bus_we === 1'b0 && busy === 1'b1)) wait2 = 1'b0;
        end
        bus_gnt = 1'b1;
        wait_done(d0, 40, ok);
        repeat (3) tick();
        tests_run++;
        if (!wait1 || !wait2) begin
            tests_failed++; $display("FAIL grant_wait_req: initial wait ok=%b regrant wait ok=%b, want 1 1", wait1, wait2);
        end
        tests_run++;
        if (we_at_wr !== 1'b1) begin tests_failed++; $display("FAIL grant_first_wr: bus_we=%b at +9, want 1", we_at_wr); end
        tests_run++;
        if (!ok || done_cyc - sc !== 20) begin
            tests_failed++; $display("FAIL grant_latency: done at +%0d (seen=%b), want +20", done_cyc - sc, ok);
        end
        tests_run++;
        r = wr_diff(w0);
        if (r != -1) begin tests_failed++; $display("FAIL grant_writes: code %0d, got %0d writes, want 3", r, wr_log.size() - w0); end
        tests_run++;
        if (viol_cnt != v0 || done_cnt - d0 !== 1) begin
            tests_failed++;
            $display("FAIL grant_protocol: %0d ungranted reads, %0d done pulses, want 0 and 1", viol_cnt - v0, done_cnt - d0);
        end
    endtask

    task automatic test_abort();
        int sc, d0, w0, r, cnt, k, ph;
        bit ok;
        logic [31:0] s, d;
        bus_gnt = 1'b1;
        // Fixed case plus randomized abort points (k = words that must still be written).
        for (int t = 0; t < 5; t++) begin
            if (t == 0) begin cnt = 8; k = 2; ph = 1; end
            else begin cnt = $urandom_range(2, 12); k = $urandom_range(1, cnt - 1); ph = $urandom_range(0, 2); end
            s = rand_addr(); d = rand_addr();
            d0 = done_cnt; w0 = wr_log.size();
            model_copy(s, d, k);
            do_start(s, d, LW'(cnt), 1'b0, sc);
            repeat (1 + 3 * (k - 1) + ph) tick();
            abort = 1'b1;
            tick();
            abort = 1'b0;
            wait_done(d0, 60, ok);
            repeat (2) tick();
            tests_run++;
            if (!ok || done_cyc - sc !== 2 + 3 * k || done_cnt - d0 !== 1) begin
                tests_failed++;
                $display("FAIL abort_done[%0d]: done at +%0d count %0d, want +%0d count 1", t, done_cyc - sc, done_cnt - d0, 2 + 3 * k);
            end
            tests_run++;
            if (remaining !== LW'(cnt - k)) begin
                tests_failed++; $display("FAIL abort_remaining[%0d]: got %0d, want %0d", t, remaining, cnt - k);
            end
            tests_run++;
            r = wr_diff(w0);
            if (r != -1) begin
                tests_failed++; $display("FAIL abort_writes[%0d]: code %0d, got %0d writes, want %0d", t, r, wr_log.size() - w0, k);
            end
        end
        d0 = done_cnt; w0 = wr_log.size();
        bus_gnt = 1'b0;
        do_start(rand_addr(), rand_addr(), LW'(5), 1'b0, sc);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (3) tick();
        bus_gnt = 1'b1;
        repeat (3) tick();
        tests_run++;
        if (done_cyc - sc !== 3 || done_cnt - d0 !== 1 || wr_log.size() != w0 || remaining !== LW'(5)) begin
            tests_failed++;
            $display("FAIL abort_in_req: done +%0d x%0d writes %0d rem %0d, want +3 x1 writes 0 rem 5",
                     done_cyc - sc, done_cnt - d0, wr_log.size() - w0, remaining);
        end
    endtask

    task automatic test_reset_mid();
        int sc, d0, w0, r;
        bit ok;
        logic we_pre;
        logic [31:0] s, d;
        bus_gnt = 1'b1;
        d0 = done_cnt; w0 = wr_log.size();
        do_start(rand_addr(), rand_addr(), LW'(4), 1'b0, sc);
        repeat (3) tick();
        we_pre = bus_we;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (we_pre !== 1'b1 || {busy, done, bus_req, bus_we, bus_be, bus_addr, bus_wdata, remaining} !== '0) begin
            tests_failed++;
            $display("FAIL rstmid_async: we before=%b outputs=%h, want 1 and all zero",
                     we_pre, {busy, done, bus_req, bus_we, bus_be, bus_addr, bus_wdata, remaining});
        end
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        tests_run++;
        if (done_cnt != d0 || wr_log.size() != w0 || bus_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_dropped: done %0d writes %0d req %b, want 0 0 0", done_cnt - d0, wr_log.size() - w0, bus_req);
        end
        s = rand_addr(); d = rand_addr();
        d0 = done_cnt; w0 = wr_log.size();
        model_copy(s, d, 3);
        do_start(s, d, LW'(3), 1'b0, sc);
        wait_done(d0, 40, ok);
        repeat (2) tick();
        tests_run++;
        r = wr_diff(w0);
        if (!ok || r != -1 || done_cyc - sc !== 11) begin
            tests_failed++;
            $display("FAIL rstmid_recopy: seen=%b code %0d done +%0d, want 1 -1 +11", ok, r, done_cyc - sc);
        end
    endtask

    task automatic test_wrap();
        int sc, d0, w0, q0, r;
        bit ok;
        logic [31:0] d, a_rd1, a_rd2;
        logic req2, we2;
        bus_gnt = 1'b1;
        d = rand_addr();
        d0 = done_cnt; w0 = wr_log.size();
        model_copy(32'hFFFF_FFFC, d, 2);
        do_start(32'hFFFF_FFFC, d, LW'(2), 1'b0, sc);
        tick();
        a_rd1 = bus_addr;
        tick();
        src_addr = rand_addr(); dst_addr = rand_addr(); word_cnt = LW'(7); start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a_rd2 = bus_addr; req2 = bus_req; we2 = bus_we;
        wait_done(d0, 30, ok);
        repeat (2) tick();
        tests_run++;
        if (a_rd1 !== 32'hFFFF_FFFC || a_rd2 !== 32'h0 || req2 !== 1'b1 || we2 !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_addr: reads at %h then %h (req %b we %b), want fffffffc then 00000000 (1 0)", a_rd1, a_rd2, req2, we2);
        end
        tests_run++;
        r = wr_diff(w0);
        if (r != -1) begin tests_failed++; $display("FAIL wrap_writes: code %0d, got %0d writes, want 2", r, wr_log.size() - w0); end
        q0 = req_cnt;
        repeat (5) tick();
        tests_run++;
        if (!ok || done_cyc - sc !== 8 || done_cnt - d0 !== 1 || req_cnt != q0) begin
            tests_failed++;
            $display("FAIL wrap_ignored_start: done +%0d x%0d, later req cycles %0d, want +8 x1 0", done_cyc - sc, done_cnt - d0, req_cnt - q0);
        end
    endtask

    task automatic test_back_to_back();
        int sc, d0, w0, v0, r, cnt;
        bit ok;
        logic [31:0] s, d;
        v0 = viol_cnt;
        for (int t = 0; t < 6; t++) begin
            s = 32'h2000_0000 | ($urandom & 32'h0000_00FF);
            d = 32'h2000_0000 | ($urandom & 32'h0000_00FF);
            cnt = $urandom_range(1, 10);
            d0 = done_cnt; w0 = wr_log.size();
            model_copy(s, d, cnt);
            do_start(s, d, LW'(cnt), (t == 0), sc);
            ok = 1'b0;
            for (int i = 0; i < 300; i++) begin
                if (done_cnt > d0) begin ok = 1'b1; break; end
                bus_gnt = 1'($urandom_range(0, 1));
                tick();
            end
            tests_run++;
            if (!ok || done_cnt - d0 !== 1) begin
                tests_failed++; $display("FAIL b2b_done[%0d]: seen=%b pulses %0d, want 1 1", t, ok, done_cnt - d0);
            end
            tests_run++;
            r = wr_diff(w0);
            if (r != -1 || remaining !== LW'(0)) begin
                tests_failed++;
                $display("FAIL b2b_copy[%0d]: code %0d writes %0d rem %0d, want -1 %0d 0", t, r, wr_log.size() - w0, remaining, cnt);
            end
        end
        tests_run++;
        if (viol_cnt != v0) begin tests_failed++; $display("FAIL b2b_grant: %0d ungranted reads, want 0", viol_cnt - v0); end
    endtask

    initial begin
        seed     = $urandom;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        src_addr = 32'h0;
        dst_addr = 32'h0;
        word_cnt = '0;
        bus_gnt  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        test_reset();
        test_basic();
        test_zero_len();
        test_grant();
        test_abort();
        test_reset_mid();
        test_wrap();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time limit, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
